// File: rtl/uart_cmd_responder_if.sv
// Signal bundle between the UART command responder and its surroundings:
// the UART RX/TX byte handshakes and the single-port register-file port.
interface uart_cmd_responder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   // UART receiver side
   logic [DATA_WIDTH-1:0] rx_p_data;
   logic                  rx_d_vld;
   // UART transmitter side
   logic [DATA_WIDTH-1:0] tx_p_data;
   logic                  tx_d_vld;
   logic                  tx_busy;
   // register file side
   logic [ADDR_WIDTH-1:0] rf_addr;
   logic [DATA_WIDTH-1:0] rf_wr_data;
   logic                  rf_wr_en;
   logic                  rf_rd_en;
   logic [DATA_WIDTH-1:0] rf_rd_data;
   logic                  rf_rd_vld;
   // protocol error strobe
   logic                  cmd_err;

   // the responder itself
   modport master (
      input  rx_p_data, rx_d_vld, tx_busy, rf_rd_data, rf_rd_vld,
      output tx_p_data, tx_d_vld, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, cmd_err
   );

   // UART + register file seen from the outside
   modport slave (
      output rx_p_data, rx_d_vld, tx_busy, rf_rd_data, rf_rd_vld,
      input  tx_p_data, tx_d_vld, rf_addr, rf_wr_data, rf_wr_en, rf_rd_en, cmd_err
   );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 0xAA addr data (write) and 0xBB addr (read)
// frames from the RX byte stream, drives the register file and returns read
// data to the UART transmitter. All outputs are registered.
module uart_cmd_responder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_cmd_responder_if.master   bus
);

   localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] ADDR_MASK = DATA_WIDTH'((1 << ADDR_WIDTH) - 1);
   localparam logic [7:0]            CNT_MAX   = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      TX_SEND
   } state_t;

   state_t                state, state_nxt;
   logic [7:0]            cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] tx_data, tx_data_nxt;
   logic                  tx_vld, tx_vld_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [DATA_WIDTH-1:0] wr_data, wr_data_nxt;
   logic                  wr_en, wr_en_nxt;
   logic                  rd_en, rd_en_nxt;
   logic                  err, err_nxt;

   logic                  addr_bad;
   logic [ADDR_WIDTH-1:0] addr_in;

   // any bit above the address field makes the address byte illegal
   assign addr_bad = |(bus.rx_p_data & ~ADDR_MASK);
   assign addr_in  = bus.rx_p_data[ADDR_WIDTH-1:0];

   // state, timeout counter and all output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         tx_data <= '0;
         tx_vld  <= 1'b0;
         addr    <= '0;
         wr_data <= '0;
         wr_en   <= 1'b0;
         rd_en   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         tx_data <= tx_data_nxt;
         tx_vld  <= tx_vld_nxt;
         addr    <= addr_nxt;
         wr_data <= wr_data_nxt;
         wr_en   <= wr_en_nxt;
         rd_en   <= rd_en_nxt;
         err     <= err_nxt;
      end
   end

   // frame parser: next state plus next value of every registered output
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tx_data_nxt = tx_data;
      tx_vld_nxt  = 1'b0;
      addr_nxt    = addr;
      wr_data_nxt = wr_data;
      wr_en_nxt   = 1'b0;
      rd_en_nxt   = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.rx_d_vld) begin
               if (bus.rx_p_data == OP_WR)      state_nxt = WR_ADDR;
               else if (bus.rx_p_data == OP_RD) state_nxt = RD_ADDR;
               else                             err_nxt   = 1'b1;
            end
         end
         WR_ADDR: begin
            if (bus.rx_d_vld) begin
               if (addr_bad) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  addr_nxt  = addr_in;
                  state_nxt = WR_DATA;
               end
            end
         end
         WR_DATA: begin
            if (bus.rx_d_vld) begin
               wr_data_nxt = bus.rx_p_data;
               wr_en_nxt   = 1'b1;
               state_nxt   = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.rx_d_vld) begin
               if (addr_bad) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  addr_nxt  = addr_in;
                  rd_en_nxt = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // stray RX bytes are dropped but flagged; read data beats timeout
            if (bus.rx_d_vld) err_nxt = 1'b1;
            if (bus.rf_rd_vld) begin
               tx_data_nxt = bus.rf_rd_data;
               // the edge that captures the data is also the first TX_BUSY sample
               if (!bus.tx_busy) begin
                  tx_vld_nxt = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt  = TX_SEND;
               end
            end else if (cnt == CNT_MAX) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         TX_SEND: begin
            if (bus.rx_d_vld) err_nxt = 1'b1;
            if (!bus.tx_busy) begin
               tx_vld_nxt = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.tx_p_data  = tx_data;
   assign bus.tx_d_vld   = tx_vld;
   assign bus.rf_addr    = addr;
   assign bus.rf_wr_data = wr_data;
   assign bus.rf_wr_en   = wr_en;
   assign bus.rf_rd_en   = rd_en;
   assign bus.cmd_err    = err;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: a frame-level reference model compared
// against the DUT every cycle, directed scenarios with literal expectations,
// then randomized frames, backpressure, stray read data and resets.
module tb_uart_cmd_responder;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   uart_cmd_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   uart_cmd_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [7:0] frame[$];
   bit         waiting, holding;
   int         issue_cyc;
   logic [7:0] e_txd, e_wd;
   logic [3:0] e_addr;
   logic       e_tx, e_wr, e_rd, e_err;

   task automatic m_step();
      e_tx = 0; e_wr = 0; e_rd = 0; e_err = 0;
      if (rst) begin
         frame.delete(); waiting = 0; holding = 0;
         e_txd = 0; e_wd = 0; e_addr = 0;
         return;
      end
      if (waiting) begin
         if (bus.rx_d_vld) e_err = 1;
         if (bus.rf_rd_vld) begin
            waiting = 0;
            e_txd   = bus.rf_rd_data;
            if (!bus.tx_busy) e_tx = 1;
            else              holding = 1;
         end else if (cyc - issue_cyc == 256) begin
            waiting = 0;
            e_err   = 1;
         end
      end else if (holding) begin
         if (bus.rx_d_vld) e_err = 1;
         if (!bus.tx_busy) begin
            e_tx    = 1;
            holding = 0;
         end
      end else if (bus.rx_d_vld) begin
         frame.push_back(bus.rx_p_data);
         if (frame.size() == 1) begin
            if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
               e_err = 1;
               frame.delete();
            end
         end else if (frame.size() == 2) begin
            if (frame[1] > 8'd15) begin
               e_err = 1;
               frame.delete();
            end else begin
               e_addr = 4'(frame[1]);
               if (frame[0] == 8'hBB) begin
                  e_rd      = 1;
                  waiting   = 1;
                  issue_cyc = cyc;
                  frame.delete();
               end
            end
         end else begin
            e_wd = frame[2];
            e_wr = 1;
            frame.delete();
         end
      end
   endtask

   // per-cycle compare of every output against the model
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         m_step();
         #1;
         check("outputs",
               32'({bus.tx_p_data, bus.tx_d_vld, bus.rf_addr, bus.rf_wr_data,
                    bus.rf_wr_en, bus.rf_rd_en, bus.cmd_err}),
               32'({e_txd, e_tx, e_addr, e_wd, e_wr, e_rd, e_err}));
      end
   end

   // ---------------- event monitor for literal checks ----------------
   int         wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0;
   int         wr_cyc, rd_cyc, tx_cyc, err_cyc;
   logic [3:0] last_wr_addr;
   logic [7:0] last_wr_data, last_tx;

   initial begin
      forever begin
         @(negedge clk);
         if (bus.rf_wr_en) begin
            wr_cnt++; wr_cyc = cyc;
            last_wr_addr = bus.rf_addr; last_wr_data = bus.rf_wr_data;
         end
         if (bus.rf_rd_en) begin rd_cnt++; rd_cyc = cyc; end
         if (bus.tx_d_vld) begin tx_cnt++; tx_cyc = cyc; last_tx = bus.tx_p_data; end
         if (bus.cmd_err)  begin err_cnt++; err_cyc = cyc; end
      end
   end

   // ---------------- register-file responder ----------------
   int         rd_delay = 3;
   bit         rd_fixed = 1;
   logic [7:0] rd_value = 8'hA5;
   bit         spur_en  = 0;

   initial begin
      int d;
      bus.rf_rd_vld  = 0;
      bus.rf_rd_data = 0;
      forever begin
         @(negedge clk);
         bus.rf_rd_vld  = spur_en && ($urandom_range(0, 15) == 0);
         bus.rf_rd_data = 8'($urandom);
         if (bus.rf_rd_en && rd_delay >= 0) begin
            d = rd_delay;
            for (int k = 0; k < d; k++) begin
               @(negedge clk);
               bus.rf_rd_vld = 0;
            end
            bus.rf_rd_vld  = 1;
            bus.rf_rd_data = rd_fixed ? rd_value : 8'($urandom);
         end
      end
   end

   // ---------------- stimulus ----------------
   bit busy_rand = 0;
   int byte_cyc;

   task automatic tick();
      @(negedge clk);
      if (busy_rand) bus.tx_busy = ($urandom_range(0, 3) == 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_p_data = b;
      bus.rx_d_vld  = 1;
      byte_cyc      = cyc;
      tick();
      bus.rx_d_vld  = 0;
      bus.rx_p_data = 8'($urandom);
   endtask

   task automatic pulse_reset();
      rst = 1;
      idle(2);
      rst = 0;
   endtask

   initial begin
      int w0, r0, t0, e0, fall_cyc, kind, gap;
      logic [7:0] a, b;
      rst = 1;
      bus.rx_p_data = 0;
      bus.rx_d_vld  = 0;
      bus.tx_busy   = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      idle(2);

      // write AA,03,5C
      w0 = wr_cnt; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5C);
      idle(3);
      check("wr_count", 32'(wr_cnt - w0), 32'd1);
      check("wr_addr", 32'(last_wr_addr), 32'h3);
      check("wr_data", 32'(last_wr_data), 32'h5C);
      check("wr_latency", 32'(wr_cyc - byte_cyc), 32'd1);
      check("wr_no_err", 32'(err_cnt - e0), 32'd0);

      // read BB,07 with data three cycles after the read strobe
      r0 = rd_cnt; t0 = tx_cnt;
      send_byte(8'hBB); send_byte(8'h07);
      idle(8);
      check("rd_count", 32'(rd_cnt - r0), 32'd1);
      check("rd_tx_count", 32'(tx_cnt - t0), 32'd1);
      check("rd_tx_data", 32'(last_tx), 32'hA5);
      check("rd_tx_latency", 32'(tx_cyc - rd_cyc), 32'd4);

      // same read under 20 cycles of TX backpressure
      t0 = tx_cnt; rd_value = 8'h3C;
      bus.tx_busy = 1;
      send_byte(8'hBB); send_byte(8'h07);
      idle(18);
      fall_cyc = cyc;
      bus.tx_busy = 0;
      idle(5);
      check("bp_tx_count", 32'(tx_cnt - t0), 32'd1);
      check("bp_tx_cycle", 32'(tx_cyc - fall_cyc), 32'd1);
      check("bp_tx_data", 32'(last_tx), 32'h3C);

      // bad opcode
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      send_byte(8'h42);
      idle(3);
      check("badop_err", 32'(err_cnt - e0), 32'd1);
      check("badop_strobes", 32'((wr_cnt - w0) + (rd_cnt - r0)), 32'd0);

      // illegal address then a normal write
      e0 = err_cnt; w0 = wr_cnt;
      send_byte(8'hAA); send_byte(8'h13);
      idle(1);
      check("badaddr_err", 32'(err_cnt - e0), 32'd1);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
      idle(3);
      check("after_err_wr", 32'(wr_cnt - w0), 32'd1);
      check("after_err_addr", 32'({last_wr_addr, last_wr_data}), 32'h1FF);

      // read timeout
      rd_delay = -1; t0 = tx_cnt; e0 = err_cnt;
      send_byte(8'hBB); send_byte(8'h02);
      idle(270);
      check("timeout_err", 32'(err_cnt - e0), 32'd1);
      check("timeout_cycle", 32'(err_cyc - rd_cyc), 32'd256);
      check("timeout_no_tx", 32'(tx_cnt - t0), 32'd0);

      // reset mid-frame discards the partial write
      w0 = wr_cnt; e0 = err_cnt;
      send_byte(8'hAA); send_byte(8'h05);
      pulse_reset();
      idle(1);
      send_byte(8'h09);
      idle(3);
      check("rst_frame_err", 32'(err_cnt - e0), 32'd1);
      check("rst_frame_no_wr", 32'(wr_cnt - w0), 32'd0);

      // randomized traffic, checked every cycle by the model
      rd_fixed = 0; spur_en = 1; busy_rand = 1;
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         gap = $urandom_range(0, 2);
         if (kind <= 3) begin
            send_byte(8'hAA); idle(gap); send_byte(a); idle(gap); send_byte(8'($urandom));
         end else if (kind <= 7) begin
            rd_delay = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, 10);
            send_byte(8'hBB); idle(gap); send_byte(a);
            idle($urandom_range(0, 15));
         end else if (kind == 8) begin
            b = 8'($urandom);
            if (b == 8'hAA || b == 8'hBB) b = 8'h42;
            send_byte(b);
         end else begin
            send_byte(8'($urandom));
         end
         idle($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) pulse_reset();
      end
      idle(300);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

- Command responder on the parallel side of the UART block.
- Parses the byte stream delivered by the UART receiver into register-write and register-read frames and drives a single-port register-file interface.
- Returns read data to the UART transmitter using its valid/busy handshake.
- Sits between the UART (RX_OUT_P/RX_OUT_V, TX_IN_P/TX_IN_V, TX_OUT_V as busy) and the system register file, in the RX clock domain.

## Interface
- DATA_WIDTH, 8, byte width on the UART side and the register-file data width.
- ADDR_WIDTH, 4, register-file address width; must be ≤ DATA_WIDTH.
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit; stable from the TX_D_VLD pulse until the next read response.
- TX_D_VLD  out  1  one-cycle transmit request.
- TX_BUSY  in  1  UART transmitter busy; a request is only issued while it is low.
- RF_ADDR  out  ADDR_WIDTH  register-file address.
- RF_WR_DATA  out  DATA_WIDTH  write data.
- RF_WR_EN  out  1  one-cycle write strobe.
- RF_RD_EN  out  1  one-cycle read strobe.
- RF_RD_DATA  in  DATA_WIDTH  read data, valid with RF_RD_VLD.
- RF_RD_VLD  in  1  read-data valid pulse.
- CMD_ERR  out  1  one-cycle error pulse.

## Operation
Frames (first byte is the opcode):
- 0xAA addr data: register write.
- 0xBB addr: register read; one response byte is sent back on TX.

Address byte rules:
- Low ADDR_WIDTH bits give the address.
- Any set bit above ADDR_WIDTH → CMD_ERR pulse, frame aborted, return to IDLE.

State machine:
- IDLE:
  - RX byte 0xAA → WR_ADDR.
  - RX byte 0xBB → RD_ADDR.
  - Any other byte → CMD_ERR pulse, stay in IDLE.
- WR_ADDR: RX byte → latch RF_ADDR → WR_DATA (or abort if the address is illegal).
- WR_DATA: RX byte → latch RF_WR_DATA, pulse RF_WR_EN → IDLE.
- RD_ADDR: RX byte → latch RF_ADDR, pulse RF_RD_EN, clear timeout counter → RD_WAIT (or abort if the address is illegal).
- RD_WAIT:
  - RF_RD_VLD → capture RF_RD_DATA into TX_P_DATA → TX_SEND.
  - Otherwise the 8-bit counter increments.
  - When the counter reaches 255 with no RF_RD_VLD → CMD_ERR pulse → IDLE; nothing is transmitted.
- TX_SEND: on the first edge sampling TX_BUSY=0 → pulse TX_D_VLD → IDLE.

Boundary conditions:
- Mid-frame waits are unbounded in WR_ADDR, WR_DATA and RD_ADDR; there is no inter-byte timeout.
- RX byte arriving in RD_WAIT or TX_SEND: dropped, CMD_ERR pulse, state unaffected.
- RF_RD_VLD in the same cycle the counter reaches 255: data wins, no error.
- RF_RD_VLD outside RD_WAIT: ignored.
- Reset at any point: partial frame discarded, state → IDLE.

## Timing
- All outputs are registered.
- Reset values: TX_P_DATA=0, TX_D_VLD=0, RF_ADDR=0, RF_WR_DATA=0, RF_WR_EN=0, RF_RD_EN=0, CMD_ERR=0, counter=0, state IDLE.
- RF_WR_EN is high exactly one cycle, in the cycle after the edge sampling the data byte's RX_D_VLD. RF_ADDR and RF_WR_DATA are valid in that same cycle.
- RF_RD_EN is high exactly one cycle, in the cycle after the edge sampling the address byte's RX_D_VLD.
- Read response latency: TX_D_VLD is high in the cycle after the edge sampling RF_RD_VLD, provided TX_BUSY=0 at that edge. Each cycle of TX_BUSY=1 delays it by one cycle.
- CMD_ERR is high in the cycle after the offending event; it is never more than one cycle wide per event.
- Back-to-back frames: the opcode of a new frame is accepted in the cycle immediately after the previous frame returns to IDLE.

## Test plan
- Write: RX AA,03,5C → one RF_WR_EN cycle with RF_ADDR=3, RF_WR_DATA=0x5C; CMD_ERR stays 0.
- Read: RX BB,07; RF_RD_VLD with 0xA5 three cycles after RF_RD_EN; TX_BUSY=0 → TX_D_VLD pulse with TX_P_DATA=0xA5 one cycle later.
- TX backpressure: same read with TX_BUSY held high for 20 cycles → TX_D_VLD is delayed until the cycle after TX_BUSY falls; exactly one pulse.
- Errors:
  - RX 42 → CMD_ERR pulse, no RF strobes.
  - RX AA,13 → CMD_ERR pulse on the address byte, then AA,01,FF is accepted normally.
- Timeout: RX BB,02 with RF_RD_VLD never asserted → CMD_ERR pulse 256 cycles after RF_RD_EN; no TX_D_VLD.
- Reset mid-frame: RX AA,05, assert RST, release, then RX 09 → CMD_ERR pulse (0x09 is treated as an opcode), no RF_WR_EN.
